prg_saver: RTL and testbench
============================

# prg_saver

Reads the BASIC program currently in main RAM and streams it out as a `.PRG` image, one byte per handshake. It is the save-direction counterpart of the PRG download path that writes RAM and patches the BASIC pointers. It sits on the `clk_sys` side of main RAM, borrowing the system-side RAM port while busy. Its byte stream feeds the HPS upload path that writes the image to storage.

## Interface
Parameters
- `PTR_START`, default 16'h002B: address of TXTTAB low byte; the high byte is at +1.
- `PTR_END`, default 16'h002D: address of the program-end pointer low byte; the high byte is at +1. The pointer is exclusive.

Ports
- `clk_sys` in 1: single clock. One clock; reset is synchronous and active-low.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request a save. Sampled only in IDLE.
- `abort` in 1: synchronous cancel of an operation in progress.
- `busy` out 1: high from the cycle after `start` is accepted until return to IDLE.
- `done` out 1: one-cycle pulse after the last byte is accepted.
- `err` out 1: one-cycle pulse when the pointers are invalid.
- `prg_len` out 16: program body length, `end - start`. Valid from CHECK until the next `start`.
- `mem_addr` out 16: RAM read address.
- `mem_rd` out 1: RAM read strobe. The top level grants the RAM port to this block while `busy`.
- `mem_din` in 8: RAM read data, valid exactly 1 cycle after `mem_rd`/`mem_addr`.
- `out_data` out 8: stream byte.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: sink accepts. A beat transfers on a rising edge with `out_valid & out_ready`.
- `out_last` out 1: qualifies the final beat.

## Operation
- States: IDLE, PTR, CHECK, HDR0, HDR1, FETCH, LATCH, SEND, FIN.
- IDLE:
  - `start`=1 → PTR.
  - `start` in any other state is ignored.
- PTR (4 cycles, pipelined):
  - `mem_addr` steps through `PTR_START`, `PTR_START+1`, `PTR_END`, `PTR_END+1`, with `mem_rd`=1 each cycle.
  - Bytes are captured one cycle later into `s_ptr`/`e_ptr` (little-endian).
- CHECK (1 cycle):
  - `prg_len` ← `e_ptr - s_ptr` (16-bit, modulo).
  - If `e_ptr <= s_ptr` (unsigned) → `err` pulse, go to IDLE. No beats are emitted.
  - Otherwise `cur` ← `s_ptr`, go to HDR0.
- HDR0: `out_data`=`s_ptr[7:0]`, `out_valid`=1. On transfer → HDR1.
- HDR1: `out_data`=`s_ptr[15:8]`. On transfer → FETCH.
- FETCH: `mem_addr`=`cur`, `mem_rd`=1, `out_valid`=0 → LATCH.
- LATCH: `out_data` ← `mem_din` → SEND.
- SEND:
  - `out_valid`=1; `out_last`=1 iff `cur == e_ptr-1`.
  - On transfer: if last → FIN; else `cur`++ → FETCH.
- FIN: `done` pulse, `busy` drops → IDLE.
- Address arithmetic:
  - 16-bit.
  - `e_ptr`=16'h0000 with `s_ptr`>0 is an error (no wrap through $FFFF).
  - `e_ptr`=16'hFFFF is legal; the last byte read is $FFFE.
- Stream rules:
  - While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
  - `out_valid` never drops without a transfer, except on `abort` or reset.
- `abort` (any non-IDLE state): next cycle IDLE, with `busy`, `out_valid`, `out_last`, `mem_rd` all 0. No `done`/`err`. `abort` has priority over a simultaneous transfer; that beat is not counted.
- `reset_n`=0: next edge forces IDLE and all outputs to reset values regardless of state.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `prg_len`=0, `mem_addr`=0, `mem_rd`=0, `out_data`=0, `out_valid`=0, `out_last`=0.
- Cycle numbering: `start` sampled at edge T; cycle T+k is the cycle after edge T+k.
  - T+1: `busy`=1, `mem_addr`=`PTR_START`, `mem_rd`=1.
  - T+1..T+4: pointer reads.
  - T+5: last pointer byte captured.
  - T+6: CHECK.
  - T+7: HDR0, `out_valid`=1 (or `err`=1 at T+7 instead, with `busy`=0 at T+8).
- Body throughput with `out_ready`=1: one beat per 3 cycles (FETCH, LATCH, SEND).
- Header beats: 1 cycle each with `out_ready`=1.
- `done` is asserted the cycle after the last transfer; `busy`=0 in that same cycle.

## Test plan
- `s_ptr`=$1001, `e_ptr`=$1004, RAM[$1001..$1003]=AA BB CC, `out_ready`=1 → beats 01 10 AA BB CC; `out_last` on CC only; `prg_len`=3; one `done` pulse; `mem_rd` never addresses $1004.
- Same image with `out_ready` toggled randomly → identical 5-beat sequence; `out_data`/`out_last` stable throughout every stall.
- `e_ptr`=`s_ptr`=$1001, then `e_ptr`=$1000 → `err` pulse at T+7 each time; zero beats; `busy`=0 at T+8.
- `s_ptr`=$FFFD, `e_ptr`=$FFFF → beats FD FF RAM[$FFFD] RAM[$FFFE]; last on the 4th beat. `e_ptr`=$0000 → `err`.
- `abort` during the second body beat → next cycle `out_valid`=0, `busy`=0, no `done`. Then `start` again → full correct stream. `start` pulses while `busy` → no restart, stream unchanged.
- `reset_n`=0 for 1 cycle mid-stream → every output at its reset value the next cycle; a subsequent `start` gives a normal stream.

Source files
------------

// File: rtl/prg_saver.sv
// Streams the BASIC program held in main RAM out as a .PRG image: a two-byte
// little-endian load address followed by the bytes from TXTTAB up to the end pointer.
module prg_saver #(
    parameter logic [15:0] PTR_START = 16'h002B,
    parameter logic [15:0] PTR_END   = 16'h002D
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] prg_len,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PTR,
        S_CHECK,
        S_HDR0,
        S_HDR1,
        S_FETCH,
        S_LATCH,
        S_SEND,
        S_FIN
    } state_t;

    state_t      state_reg;
    logic [2:0]  ptr_cnt_reg;
    logic [15:0] s_ptr_reg;
    logic [15:0] e_ptr_reg;
    logic [15:0] cur_reg;

    logic        xfer;
    logic [15:0] e_last;
    logic [15:0] cur_next;

    assign xfer     = out_valid & out_ready;
    assign e_last   = e_ptr_reg - 16'd1;
    assign cur_next = cur_reg + 16'd1;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            ptr_cnt_reg <= 3'd0;
            s_ptr_reg   <= 16'd0;
            e_ptr_reg   <= 16'd0;
            cur_reg     <= 16'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            prg_len     <= 16'd0;
            mem_addr    <= 16'd0;
            mem_rd      <= 1'b0;
            out_data    <= 8'd0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // A cancel wins over everything, including a beat accepted this cycle.
            if (abort && state_reg != S_IDLE) begin
                state_reg <= S_IDLE;
                busy      <= 1'b0;
                mem_rd    <= 1'b0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            state_reg   <= S_PTR;
                            busy        <= 1'b1;
                            ptr_cnt_reg <= 3'd0;
                            mem_addr    <= PTR_START;
                            mem_rd      <= 1'b1;
                        end
                    end
                    // Issue four pointer reads back to back; each byte lands one
                    // cycle after its address, so capture trails issue by one step.
                    S_PTR: begin
                        ptr_cnt_reg <= ptr_cnt_reg + 3'd1;
                        case (ptr_cnt_reg)
                            3'd0: mem_addr <= PTR_START + 16'd1;
                            3'd1: begin
                                s_ptr_reg[7:0] <= mem_din;
                                mem_addr       <= PTR_END;
                            end
                            3'd2: begin
                                s_ptr_reg[15:8] <= mem_din;
                                mem_addr        <= PTR_END + 16'd1;
                            end
                            3'd3: begin
                                e_ptr_reg[7:0] <= mem_din;
                                mem_rd         <= 1'b0;
                            end
                            default: begin
                                e_ptr_reg[15:8] <= mem_din;
                                state_reg       <= S_CHECK;
                            end
                        endcase
                    end
                    S_CHECK: begin
                        prg_len <= e_ptr_reg - s_ptr_reg;
                        if (e_ptr_reg <= s_ptr_reg) begin
                            err       <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            cur_reg   <= s_ptr_reg;
                            out_data  <= s_ptr_reg[7:0];
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            state_reg <= S_HDR0;
                        end
                    end
                    S_HDR0: begin
                        if (xfer) begin
                            out_data  <= s_ptr_reg[15:8];
                            state_reg <= S_HDR1;
                        end
                    end
                    S_HDR1: begin
                        if (xfer) begin
                            out_valid <= 1'b0;
                            mem_addr  <= cur_reg;
                            mem_rd    <= 1'b1;
                            state_reg <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        mem_rd    <= 1'b0;
                        state_reg <= S_LATCH;
                    end
                    S_LATCH: begin
                        out_data  <= mem_din;
                        out_valid <= 1'b1;
                        out_last  <= (cur_reg == e_last);
                        state_reg <= S_SEND;
                    end
                    S_SEND: begin
                        if (xfer) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (out_last) begin
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                state_reg <= S_FIN;
                            end else begin
                                cur_reg   <= cur_next;
                                mem_addr  <= cur_next;
                                mem_rd    <= 1'b1;
                                state_reg <= S_FETCH;
                            end
                        end
                    end
                    S_FIN: begin
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                        mem_rd    <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prg_saver.sv
// Directed bench for prg_saver: a RAM model, a beat scoreboard fed at start time,
// and a negedge monitor that pops and checks every accepted beat.
module tb_prg_saver;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] prg_len;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [7:0]  ram [0:65535];

    int          checks = 0;
    int          passes = 0;
    logic [8:0]  exp_q [$];
    int          beats_seen = 0;
    int          done_count = 0;
    int          err_count = 0;
    logic        forbid_en = 1'b0;
    logic [15:0] forbid_addr = 16'd0;

    logic        prev_stall = 1'b0;
    logic        prev_abort = 1'b0;
    logic        prev_rst = 1'b0;
    logic [7:0]  prev_data = 8'd0;
    logic        prev_last = 1'b0;

    always #5 clk_sys = ~clk_sys;

    prg_saver #(.PTR_START(16'h002B), .PTR_END(16'h002D)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .prg_len   (prg_len),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_din   (mem_din),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    // Registered-read RAM: data appears the cycle after the address/strobe.
    always @(posedge clk_sys) begin
        if (mem_rd) mem_din <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk_sys);
            if (prev_stall && !prev_abort && prev_rst) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_data", {24'd0, out_data}, {24'd0, prev_data});
                check("hold_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (forbid_en && mem_rd)
                check("no_read_of_end", {31'd0, mem_addr == forbid_addr}, 32'd0);
            if (out_valid && out_ready && !abort && reset_n) begin
                check("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("beat %0d: data=%02h last=%0b expected data=%02h last=%0b",
                             beats_seen, out_data, out_last, e[7:0], e[8]);
                    check("beat_data", {24'd0, out_data}, {24'd0, e[7:0]});
                    check("beat_last", {31'd0, out_last}, {31'd0, e[8]});
                end
                beats_seen++;
            end
            if (done) done_count++;
            if (err) err_count++;
            prev_stall = out_valid && !out_ready;
            prev_abort = abort;
            prev_rst   = reset_n;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic set_image(input logic [15:0] s, input logic [15:0] e);
        ram[16'h002B] = s[7:0];
        ram[16'h002C] = s[15:8];
        ram[16'h002D] = e[7:0];
        ram[16'h002E] = e[15:8];
    endtask

    task automatic push_expected(input logic [15:0] s, input logic [15:0] e);
        exp_q.push_back({1'b0, s[7:0]});
        exp_q.push_back({1'b0, s[15:8]});
        for (int a = int'(s); a < int'(e); a++)
            exp_q.push_back({a == int'(e) - 1, ram[a]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_prg_len"}, {16'd0, prg_len}, 32'd0);
        check({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        check({tag, "_mem_rd"}, {31'd0, mem_rd}, 32'd0);
        check({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    endtask

    task automatic run_save(input logic [15:0] s, input logic [15:0] e,
                            input bit rand_ready, input bit start_noise);
        bit          exp_err;
        bit          finished;
        int          k;
        int          d0;
        int          r0;
        int          b0;
        int          exp_beats;
        logic [15:0] exp_len;
        exp_err   = (e <= s);
        exp_len   = e - s;
        exp_beats = exp_err ? 0 : int'(e) - int'(s) + 2;
        set_image(s, e);
        if (!exp_err) push_expected(s, e);
        forbid_addr = e;
        forbid_en   = 1'b1;
        d0 = done_count;
        r0 = err_count;
        b0 = beats_seen;
        $display("save s=%04h e=%04h rand_ready=%0b start_noise=%0b", s, e, rand_ready, start_noise);
        start     = 1'b1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        k = 1;
        finished = 1'b0;
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_mem_addr", {16'd0, mem_addr}, 32'h002B);
        check("t1_mem_rd", {31'd0, mem_rd}, 32'd1);
        while (!finished && k < 400) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start     = start_noise && (k % 5 == 0);
            tick();
            k++;
            if (k == 7) begin
                check("t7_valid", {31'd0, out_valid}, {31'd0, !exp_err});
                check("t7_err", {31'd0, err}, {31'd0, exp_err});
                check("t7_prg_len", {16'd0, prg_len}, {16'd0, exp_len});
            end
            if (exp_err && k == 8) begin
                check("t8_busy", {31'd0, busy}, 32'd0);
                finished = 1'b1;
            end
            if (!exp_err && done) begin
                check("done_busy_low", {31'd0, busy}, 32'd0);
                check("done_valid_low", {31'd0, out_valid}, 32'd0);
                finished = 1'b1;
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("run_finished", {31'd0, finished}, 32'd1);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("done_count", done_count - d0, exp_err ? 0 : 1);
        check("err_count", err_count - r0, exp_err ? 1 : 0);
        check("beat_count", beats_seen - b0, exp_beats);
        check("sb_drained", exp_q.size(), 32'd0);
        forbid_en = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        int k;
        int b0;
        int d0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'(i ^ (i >> 8) ^ 8'h5C);
        ram[16'h1001] = 8'hAA;
        ram[16'h1002] = 8'hBB;
        ram[16'h1003] = 8'hCC;
        ram[16'h1004] = 8'hDD;
        ram[16'hFFFD] = 8'h5A;
        ram[16'hFFFE] = 8'hC3;
        ram[16'hFFFF] = 8'h77;
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        run_save(16'h1001, 16'h1004, 1'b0, 1'b0);
        run_save(16'h1001, 16'h1004, 1'b1, 1'b0);
        run_save(16'h1001, 16'h1001, 1'b0, 1'b0);
        run_save(16'h1001, 16'h1000, 1'b0, 1'b0);
        run_save(16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        run_save(16'hFFFD, 16'h0000, 1'b0, 1'b0);

        // Abort while the second body beat is being offered.
        $display("abort during second body beat");
        set_image(16'h1001, 16'h1004);
        push_expected(16'h1001, 16'h1004);
        b0 = beats_seen;
        d0 = done_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (beats_seen - b0 < 3 && k < 100) begin
            tick();
            k++;
        end
        check("abort_reach", beats_seen - b0, 3);
        out_ready = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick();
            k++;
        end
        check("abort_at_send", {31'd0, out_valid}, 32'd1);
        check("abort_at_send_data", {24'd0, out_data}, 32'hBB);
        abort     = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", {31'd0, out_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_last", {31'd0, out_last}, 32'd0);
        check("abort_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("abort_left", exp_q.size(), 32'd2);
        exp_q.delete();
        repeat (5) tick();
        check("abort_no_done", done_count - d0, 0);
        check("abort_beats", beats_seen - b0, 3);

        run_save(16'h1001, 16'h1004, 1'b0, 1'b1);

        // Reset pulse in the middle of a stream.
        $display("reset mid-stream");
        set_image(16'h1001, 16'h1004);
        push_expected(16'h1001, 16'h1004);
        b0 = beats_seen;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (beats_seen - b0 < 2 && k < 100) begin
            tick();
            k++;
        end
        check("rst_reach", beats_seen - b0, 2);
        reset_n = 1'b0;
        tick();
        check_reset_outputs("midrst");
        reset_n = 1'b1;
        exp_q.delete();
        tick();

        run_save(16'h1001, 16'h1004, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
